// File: rtl/ogut_denetleyici_if.sv
// ogut_denetleyici_if -- signal bundle around the grind order controller.
//
// Order side (source -> controller):
//   siparis_gecerli / siparis_hazir : valid/ready pair; an order transfers
//     on the rising edge where both are 1. The source holds siparis_cekirdek
//     and siparis_boyut stable until that edge.
// Grinder side (controller -> grinder):
//   basla, cekirdekler, boyut       : one-cycle start with the batch count and size
//   bitti, tanecikler               : grinder done pulse and result (valid with bitti)
// Result side:
//   toplam_tanecik, tamam, hata     : order total, completion pulse, error pulse
//
// modport master : the controller itself (it initiates grinder batches)
// modport slave  : the environment (order source plus grinder)
interface ogut_denetleyici_if;
  logic       siparis_gecerli;
  logic       siparis_hazir;
  logic [7:0] siparis_cekirdek;
  logic [1:0] siparis_boyut;
  logic       basla;
  logic [3:0] cekirdekler;
  logic [1:0] boyut;
  logic       bitti;
  logic [4:0] tanecikler;
  logic [8:0] toplam_tanecik;
  logic       tamam;
  logic       hata;

  modport master (
    input  siparis_gecerli, siparis_cekirdek, siparis_boyut, bitti, tanecikler,
    output siparis_hazir, basla, cekirdekler, boyut, toplam_tanecik, tamam, hata
  );

  modport slave (
    output siparis_gecerli, siparis_cekirdek, siparis_boyut, bitti, tanecikler,
    input  siparis_hazir, basla, cekirdekler, boyut, toplam_tanecik, tamam, hata
  );
endinterface

// File: rtl/ogut_denetleyici.sv
// ogut_denetleyici -- order-side controller for the grinder.
// Takes an order (bean count + grind size), splits it into batches of at most
// PARTI_MAKS beans, starts the grinder once per batch and sums the returned
// tanecikler into toplam_tanecik. Aborts with hata on an illegal size (11) or
// when the grinder stays silent for ZAMAN_ASIMI cycles.
//
// Ports:
//   saat   : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : ogut_denetleyici_if.master (order, grinder and result signals)
//   durum  : current FSM state (BOSTA=0, ISTE=1, BEKLE=2, BITIR=3), debug only
module ogut_denetleyici #(
  parameter int PARTI_MAKS  = 15,
  parameter int ZAMAN_ASIMI = 8
) (
  input  logic                  saat,
  input  logic                  reset,
  ogut_denetleyici_if.master    bus,
  output logic [1:0]            durum
);

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTE  = 2'd1,
    BEKLE = 2'd2,
    BITIR = 2'd3
  } durum_t;

  // sayac only has to reach ZAMAN_ASIMI-1
  localparam int SW = (ZAMAN_ASIMI > 2) ? $clog2(ZAMAN_ASIMI) : 1;
  localparam logic [SW-1:0] SAYAC_SON = SW'(ZAMAN_ASIMI - 1);
  localparam logic [7:0]    PARTI_8   = 8'(PARTI_MAKS);
  localparam logic [3:0]    PARTI_4   = 4'(PARTI_MAKS);

  durum_t        durum_q, durum_d;
  logic [7:0]    kalan;
  logic [1:0]    boyut_r;
  logic [3:0]    parti;
  logic [SW-1:0] sayac;
  logic [8:0]    toplam;
  logic          hata_r;

  logic kabul;
  logic boyut_hatali;
  logic zaman_doldu;

  function automatic logic [3:0] parti_hesap(input logic [7:0] k);
    return (k > PARTI_8) ? PARTI_4 : k[3:0];
  endfunction

  assign kabul        = (durum_q == BOSTA) && bus.siparis_gecerli;
  assign boyut_hatali = (bus.siparis_boyut == 2'b11);
  assign zaman_doldu  = (durum_q == BEKLE) && !bus.bitti && (sayac == SAYAC_SON);

  // State register
  always_ff @(posedge saat) begin
    if (reset) durum_q <= BOSTA;
    else       durum_q <= durum_d;
  end

  // Next-state logic
  always_comb begin
    durum_d = durum_q;
    case (durum_q)
      BOSTA: begin
        if (kabul && !boyut_hatali)
          durum_d = (bus.siparis_cekirdek == 8'd0) ? BITIR : ISTE;
      end
      ISTE:  durum_d = BEKLE;
      BEKLE: begin
        if (bus.bitti)       durum_d = (kalan == 8'd0) ? BITIR : ISTE;
        else if (zaman_doldu) durum_d = BOSTA;
      end
      BITIR: durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
  end

  // Datapath. parti is loaded on every entry into ISTE so the grinder-facing
  // outputs come straight from registers and never from bitti.
  always_ff @(posedge saat) begin
    if (reset) begin
      kalan   <= 8'd0;
      boyut_r <= 2'd0;
      parti   <= 4'd0;
      sayac   <= '0;
      toplam  <= 9'd0;
      hata_r  <= 1'b0;
    end else begin
      hata_r <= (kabul && boyut_hatali) || zaman_doldu;
      case (durum_q)
        BOSTA: begin
          if (kabul) begin
            kalan   <= bus.siparis_cekirdek;
            boyut_r <= bus.siparis_boyut;
            toplam  <= 9'd0;
            parti   <= parti_hesap(bus.siparis_cekirdek);
          end
        end
        ISTE: begin
          kalan <= kalan - {4'd0, parti};
          sayac <= '0;
        end
        BEKLE: begin
          if (bus.bitti) begin
            toplam <= toplam + {4'd0, bus.tanecikler};
            parti  <= parti_hesap(kalan);
          end else begin
            sayac <= sayac + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.siparis_hazir  = (durum_q == BOSTA);
    bus.basla          = (durum_q == ISTE);
    bus.cekirdekler    = (durum_q == ISTE) ? parti   : 4'd0;
    bus.boyut          = (durum_q == ISTE) ? boyut_r : 2'd0;
    bus.tamam          = (durum_q == BITIR);
    bus.hata           = hata_r;
    bus.toplam_tanecik = toplam;
    durum              = durum_q;
  end

endmodule

// File: tb/tb_ogut_denetleyici.sv
module tb_ogut_denetleyici;

  logic       saat = 1'b0;
  logic       reset;
  logic [1:0] durum;
  ogut_denetleyici_if bus ();

  int n_assert = 0;
  int n_fail   = 0;

  // grinder model state
  logic       bitti_m = 1'b0;
  logic [4:0] tan_m   = 5'd0;
  logic       tut     = 1'b0;  // withhold bitti
  logic       zorla   = 1'b0;  // stray bitti injection

  always #5 saat = ~saat;

  ogut_denetleyici #(.PARTI_MAKS(15), .ZAMAN_ASIMI(8)) dut (
    .saat  (saat),
    .reset (reset),
    .bus   (bus.master),
    .durum (durum)
  );

  function automatic logic [4:0] carp(input logic [3:0] c, input logic [1:0] b);
    case (b)
      2'b00:   return {c, 1'b0};
      2'b01:   return {1'b0, c};
      default: return {1'b0, c} + {2'b00, c[3:1]};
    endcase
  endfunction

  // Grinder: registered done, one cycle after basla
  always @(posedge saat) begin
    bitti_m <= bus.basla && !tut;
    tan_m   <= carp(bus.cekirdekler, bus.boyut);
  end
  assign bus.bitti      = bitti_m | zorla;
  assign bus.tanecikler = zorla ? 5'd7 : tan_m;

  task automatic adim();
    @(posedge saat);
    #1;
  endtask

  task automatic kontrol(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one legal order from cycle 0; ends in cycle ex_tamam+1.
  task automatic siparis(input int n, input logic [1:0] b, input int ex_tamam, input int ex_toplam);
    int kalan_m;
    int p;
    kontrol("hazir_c0", 16'(bus.siparis_hazir), 16'd1);
    bus.siparis_gecerli  = 1'b1;
    bus.siparis_cekirdek = 8'(n);
    bus.siparis_boyut    = b;
    kalan_m = n;
    for (int c = 1; c <= ex_tamam + 1; c++) begin
      adim();
      bus.siparis_gecerli = 1'b0;
      if (c < ex_tamam && (c % 2) == 1) begin
        p = (kalan_m > 15) ? 15 : kalan_m;
        kontrol("basla_iste", 16'(bus.basla), 16'd1);
        kontrol("cekirdekler", 16'(bus.cekirdekler), 16'(p));
        kontrol("boyut", 16'(bus.boyut), 16'(b));
        kalan_m -= p;
      end else begin
        kontrol("basla_idle", 16'(bus.basla), 16'd0);
      end
      kontrol("tamam", 16'(bus.tamam), 16'(c == ex_tamam));
      kontrol("hata_none", 16'(bus.hata), 16'd0);
      kontrol("hazir", 16'(bus.siparis_hazir), 16'(c == ex_tamam + 1));
      if (c == ex_tamam) kontrol("toplam", 16'(bus.toplam_tanecik), 16'(ex_toplam));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.siparis_gecerli  = 1'b0;
    bus.siparis_cekirdek = 8'd0;
    bus.siparis_boyut    = 2'd0;
    adim();
    adim();
    reset = 1'b0;
    adim();
    // reset values
    kontrol("rst_durum", 16'(durum), 16'd0);
    kontrol("rst_hazir", 16'(bus.siparis_hazir), 16'd1);
    kontrol("rst_basla", 16'(bus.basla), 16'd0);
    kontrol("rst_cek", 16'(bus.cekirdekler), 16'd0);
    kontrol("rst_boyut", 16'(bus.boyut), 16'd0);
    kontrol("rst_tamam", 16'(bus.tamam), 16'd0);
    kontrol("rst_hata", 16'(bus.hata), 16'd0);
    kontrol("rst_toplam", 16'(bus.toplam_tanecik), 16'd0);

    // directed orders: N, size, tamam cycle, expected total
    siparis(10, 2'b00, 3, 20);
    siparis(40, 2'b00, 7, 80);
    siparis(255, 2'b00, 35, 510);
    siparis(0, 2'b00, 1, 0);
    kontrol("hold_after_n0", 16'(bus.toplam_tanecik), 16'd0);
    siparis(20, 2'b01, 5, 20);
    siparis(10, 2'b10, 3, 15);
    kontrol("hold_after_done", 16'(bus.toplam_tanecik), 16'd15);

    // illegal size
    bus.siparis_gecerli  = 1'b1;
    bus.siparis_cekirdek = 8'd5;
    bus.siparis_boyut    = 2'b11;
    adim();
    bus.siparis_gecerli = 1'b0;
    bus.siparis_boyut   = 2'b00;
    kontrol("ill_hata_c1", 16'(bus.hata), 16'd1);
    kontrol("ill_hazir_c1", 16'(bus.siparis_hazir), 16'd1);
    kontrol("ill_basla_c1", 16'(bus.basla), 16'd0);
    kontrol("ill_tamam_c1", 16'(bus.tamam), 16'd0);
    adim();
    kontrol("ill_hata_c2", 16'(bus.hata), 16'd0);
    kontrol("ill_basla_c2", 16'(bus.basla), 16'd0);
    kontrol("ill_tamam_c2", 16'(bus.tamam), 16'd0);
    kontrol("ill_hazir_c2", 16'(bus.siparis_hazir), 16'd1);

    // timeout: first batch answered, second withheld
    bus.siparis_gecerli  = 1'b1;
    bus.siparis_cekirdek = 8'd20;
    adim();                       // cycle 1: ISTE 15
    bus.siparis_gecerli = 1'b0;
    kontrol("to_basla1", 16'(bus.basla), 16'd1);
    adim();                       // cycle 2: BEKLE with bitti
    adim();                       // cycle 3: ISTE 5
    tut = 1'b1;
    kontrol("to_cek2", 16'(bus.cekirdekler), 16'd5);
    kontrol("to_partial", 16'(bus.toplam_tanecik), 16'd30);
    for (int i = 0; i < 8; i++) begin  // cycles 4..11: BEKLE, no bitti
      adim();
      kontrol("to_wait_basla", 16'(bus.basla), 16'd0);
      kontrol("to_wait_hata", 16'(bus.hata), 16'd0);
      kontrol("to_wait_hazir", 16'(bus.siparis_hazir), 16'd0);
    end
    adim();                       // cycle 12
    kontrol("to_hata", 16'(bus.hata), 16'd1);
    kontrol("to_hazir", 16'(bus.siparis_hazir), 16'd1);
    kontrol("to_tamam", 16'(bus.tamam), 16'd0);
    kontrol("to_toplam", 16'(bus.toplam_tanecik), 16'd30);
    adim();                       // cycle 13
    kontrol("to_hata_off", 16'(bus.hata), 16'd0);
    kontrol("to_toplam_hold", 16'(bus.toplam_tanecik), 16'd30);
    tut = 1'b0;
    siparis(10, 2'b00, 3, 20);

    // reset in BEKLE of a 3-batch order
    bus.siparis_gecerli  = 1'b1;
    bus.siparis_cekirdek = 8'd40;
    adim();                       // cycle 1: ISTE
    bus.siparis_gecerli = 1'b0;
    adim();                       // cycle 2: BEKLE with bitti
    adim();                       // cycle 3: ISTE
    tut = 1'b1;
    adim();                       // cycle 4: BEKLE, no bitti
    kontrol("mr_toplam_before", 16'(bus.toplam_tanecik), 16'd30);
    reset = 1'b1;
    adim();                       // cycle 5
    reset = 1'b0;
    kontrol("mr_basla", 16'(bus.basla), 16'd0);
    kontrol("mr_hazir", 16'(bus.siparis_hazir), 16'd1);
    kontrol("mr_cek", 16'(bus.cekirdekler), 16'd0);
    kontrol("mr_boyut", 16'(bus.boyut), 16'd0);
    kontrol("mr_tamam", 16'(bus.tamam), 16'd0);
    kontrol("mr_hata", 16'(bus.hata), 16'd0);
    kontrol("mr_toplam", 16'(bus.toplam_tanecik), 16'd0);
    zorla = 1'b1;
    adim();
    zorla = 1'b0;
    tut   = 1'b0;
    kontrol("mr_stray_toplam", 16'(bus.toplam_tanecik), 16'd0);
    kontrol("mr_stray_basla", 16'(bus.basla), 16'd0);
    kontrol("mr_stray_hata", 16'(bus.hata), 16'd0);
    adim();
    kontrol("mr_stray_toplam2", 16'(bus.toplam_tanecik), 16'd0);
    kontrol("mr_stray_tamam", 16'(bus.tamam), 16'd0);
    kontrol("mr_hazir2", 16'(bus.siparis_hazir), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
